// File: rtl/vga_sync_generator_pkg.sv
// vga_sync_generator_pkg
//   Shared definitions for the VGA sync generator: default 640x480@60
//   timing, the per-axis phase encoding and the count-to-phase decode.
package vga_sync_generator_pkg;

  typedef enum logic [1:0] {
    PH_VISIBLE = 2'd0,
    PH_FRONT   = 2'd1,
    PH_SYNC    = 2'd2,
    PH_BACK    = 2'd3
  } phase_e;

  localparam int DEF_H_VISIBLE     = 640;
  localparam int DEF_H_FRONT       = 16;
  localparam int DEF_H_SYNC        = 96;
  localparam int DEF_H_BACK        = 48;
  localparam int DEF_V_VISIBLE     = 480;
  localparam int DEF_V_FRONT       = 10;
  localparam int DEF_V_SYNC        = 2;
  localparam int DEF_V_BACK        = 33;
  localparam int DEF_CLK_DIV       = 4;
  localparam int DEF_COUNTER_WIDTH = 10;

  // Phase that owns a given count. Zero-length regions collapse to an
  // empty range, so they are skipped naturally.
  function automatic phase_e phase_of(input int count, input int vis,
                                      input int front, input int sync);
    if (count < vis)                    return PH_VISIBLE;
    else if (count < vis + front)       return PH_FRONT;
    else if (count < vis + front + sync) return PH_SYNC;
    else                                return PH_BACK;
  endfunction

endpackage

// File: rtl/vga_sync_generator_axis.sv
// vga_sync_axis
//   One timing axis: position counter, phase FSM and registered sync.
//   Ports:
//     Clk, rst_n   clock, async active-low reset
//     Advance      step the counter by one (pixel tick or line wrap)
//     Clear        synchronous return to the reset state
//     Count        current position (registered)
//     Phase_Next   phase that will be registered on this edge
//     Sync         registered sync level
//     Wrap         combinational: this Advance moves TOTAL-1 -> 0
//
//   state      | meaning
//   PH_VISIBLE | count in [0, VIS-1]
//   PH_FRONT   | front porch
//   PH_SYNC    | sync pulse, Sync driven to SYNC_ACTIVE
//   PH_BACK    | back porch up to TOTAL-1; also the reset/idle state
module vga_sync_axis
  import vga_sync_generator_pkg::*;
#(
  parameter int   VIS           = 640,
  parameter int   FRONT         = 16,
  parameter int   SYNC          = 96,
  parameter int   BACK          = 48,
  parameter logic SYNC_ACTIVE   = 1'b0,
  parameter int   COUNTER_WIDTH = 10
) (
  input  logic                     Clk,
  input  logic                     rst_n,
  input  logic                     Advance,
  input  logic                     Clear,
  output logic [COUNTER_WIDTH-1:0] Count,
  output logic [1:0]               Phase_Next,
  output logic                     Sync,
  output logic                     Wrap
);

  localparam int TOTAL = VIS + FRONT + SYNC + BACK;
  localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(TOTAL - 1);

  phase_e                   phase;
  phase_e                   phase_nxt;
  logic [COUNTER_WIDTH-1:0] count_nxt;

  always_comb begin
    Wrap      = Advance && !Clear && (Count == LAST);
    count_nxt = Count;
    phase_nxt = phase;
    if (Clear) begin
      count_nxt = LAST;
      phase_nxt = PH_BACK;
    end else if (Advance) begin
      count_nxt = Wrap ? '0 : Count + 1'b1;
      phase_nxt = phase_of(int'(count_nxt), VIS, FRONT, SYNC);
    end
  end

  assign Phase_Next = phase_nxt;

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      Count <= LAST;
      phase <= PH_BACK;
      Sync  <= ~SYNC_ACTIVE;
    end else begin
      Count <= count_nxt;
      phase <= phase_nxt;
      Sync  <= (phase_nxt == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

endmodule

// File: rtl/vga_sync_generator.sv
// vga_sync_generator
//   VGA horizontal/vertical timing generator. Divides Clk into a pixel
//   tick, runs H and V axes and registers sync, visible-area and
//   line/frame start strobes.
//   Ports:
//     Clk, rst_n    system clock, async active-low reset
//     Enable        1 = run, 0 = synchronously hold the reset state
//     Pix_Tick      one-Clk strobe per pixel
//     HSync, VSync  sync outputs (active level SYNC_ACTIVE)
//     Video_On      inside the visible area
//     Line_Start    one-Clk strobe when H wraps to 0
//     Frame_Start   one-Clk strobe when H and V both wrap to 0
//     H_Count       current column
//     V_Count       current line
module vga_sync_generator
  import vga_sync_generator_pkg::*;
#(
  parameter int   H_VISIBLE     = DEF_H_VISIBLE,
  parameter int   H_FRONT       = DEF_H_FRONT,
  parameter int   H_SYNC        = DEF_H_SYNC,
  parameter int   H_BACK        = DEF_H_BACK,
  parameter int   V_VISIBLE     = DEF_V_VISIBLE,
  parameter int   V_FRONT       = DEF_V_FRONT,
  parameter int   V_SYNC        = DEF_V_SYNC,
  parameter int   V_BACK        = DEF_V_BACK,
  parameter logic SYNC_ACTIVE   = 1'b0,
  parameter int   CLK_DIV       = DEF_CLK_DIV,
  parameter int   COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
  input  logic                     Clk,
  input  logic                     rst_n,
  input  logic                     Enable,
  output logic                     Pix_Tick,
  output logic                     HSync,
  output logic                     VSync,
  output logic                     Video_On,
  output logic                     Line_Start,
  output logic                     Frame_Start,
  output logic [COUNTER_WIDTH-1:0] H_Count,
  output logic [COUNTER_WIDTH-1:0] V_Count
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             clear;
  logic             h_wrap;
  logic             v_wrap;
  logic [1:0]       h_phase_nxt;
  logic [1:0]       v_phase_nxt;

  // The counters step on the same edge that raises Pix_Tick, so the new
  // position and the strobe become visible together.
  assign clear = !Enable;
  assign tick  = Enable && (div_cnt == DIV_LAST);

  vga_sync_axis #(
    .VIS(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .SYNC_ACTIVE(SYNC_ACTIVE), .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_h_axis (
    .Clk(Clk), .rst_n(rst_n), .Advance(tick), .Clear(clear),
    .Count(H_Count), .Phase_Next(h_phase_nxt), .Sync(HSync), .Wrap(h_wrap)
  );

  // V steps only when H wraps, so VSync changes on line boundaries.
  vga_sync_axis #(
    .VIS(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .SYNC_ACTIVE(SYNC_ACTIVE), .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_v_axis (
    .Clk(Clk), .rst_n(rst_n), .Advance(h_wrap), .Clear(clear),
    .Count(V_Count), .Phase_Next(v_phase_nxt), .Sync(VSync), .Wrap(v_wrap)
  );

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      Pix_Tick    <= 1'b0;
      Line_Start  <= 1'b0;
      Frame_Start <= 1'b0;
      Video_On    <= 1'b0;
    end else if (!Enable) begin
      div_cnt     <= '0;
      Pix_Tick    <= 1'b0;
      Line_Start  <= 1'b0;
      Frame_Start <= 1'b0;
      Video_On    <= 1'b0;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + 1'b1;
      Pix_Tick    <= tick;
      Line_Start  <= h_wrap;
      Frame_Start <= h_wrap && v_wrap;
      Video_On    <= (h_phase_nxt == 2'(PH_VISIBLE)) &&
                     (v_phase_nxt == 2'(PH_VISIBLE));
    end
  end

endmodule

// File: tb/tb_vga_sync_generator.sv
module tb_vga_sync_generator;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // A: 640x480 timing, one clock per pixel
  logic a_rst, a_en, a_pt, a_hs, a_vs, a_vo, a_ls, a_fs;
  logic [9:0] a_hc, a_vc;
  vga_sync_generator #(.CLK_DIV(1)) dut_a (
    .Clk(Clk), .rst_n(a_rst), .Enable(a_en), .Pix_Tick(a_pt), .HSync(a_hs),
    .VSync(a_vs), .Video_On(a_vo), .Line_Start(a_ls), .Frame_Start(a_fs),
    .H_Count(a_hc), .V_Count(a_vc));

  // B: tiny timing, 12 x 8 totals, one clock per pixel
  logic b_rst, b_en, b_pt, b_hs, b_vs, b_vo, b_ls, b_fs;
  logic [9:0] b_hc, b_vc;
  vga_sync_generator #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .CLK_DIV(1)
  ) dut_b (
    .Clk(Clk), .rst_n(b_rst), .Enable(b_en), .Pix_Tick(b_pt), .HSync(b_hs),
    .VSync(b_vs), .Video_On(b_vo), .Line_Start(b_ls), .Frame_Start(b_fs),
    .H_Count(b_hc), .V_Count(b_vc));

  // C: 640x480 timing, four clocks per pixel
  logic c_rst, c_en, c_pt, c_hs, c_vs, c_vo, c_ls, c_fs;
  logic [9:0] c_hc, c_vc;
  vga_sync_generator #(.CLK_DIV(4)) dut_c (
    .Clk(Clk), .rst_n(c_rst), .Enable(c_en), .Pix_Tick(c_pt), .HSync(c_hs),
    .VSync(c_vs), .Video_On(c_vo), .Line_Start(c_ls), .Frame_Start(c_fs),
    .H_Count(c_hc), .V_Count(c_vc));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, n_low, first_low, last_low, fall_h, found;
    int vs_bad, hs_bad, seq_bad, exp_line, fs_cnt, last_fs, fs_period, vs_low;
    int stable_bad, tick_bad, prev_h;
    logic vid_prev;

    a_rst = 0; b_rst = 0; c_rst = 0;
    a_en = 1;  b_en = 1;  c_en = 1;
    repeat (3) step();

    // ---------------- reset state ----------------
    check("rst_h_count", a_hc, 799);
    check("rst_v_count", a_vc, 524);
    check("rst_hsync", a_hs, 1);
    check("rst_vsync", a_vs, 1);
    check("rst_video_on", a_vo, 0);
    check("rst_pix_tick", a_pt, 0);
    check("rst_line_start", a_ls, 0);
    check("rst_frame_start", a_fs, 0);
    check("rst_small_h", b_hc, 11);
    check("rst_small_v", b_vc, 7);

    // ---------------- A: first tick and one full line ----------------
    a_rst = 1;
    step();
    check("a_first_h", a_hc, 0);
    check("a_first_v", a_vc, 0);
    check("a_first_frame_start", a_fs, 1);
    check("a_first_line_start", a_ls, 1);
    check("a_first_video_on", a_vo, 1);
    check("a_first_pix_tick", a_pt, 1);
    check("a_first_hsync", a_hs, 1);

    cyc = 0; n_low = 0; first_low = -1; last_low = -1; fall_h = -1;
    vid_prev = 1'b1; found = 0;
    for (int k = 0; k < 2000; k++) begin
      step();
      cyc++;
      if (cyc == 1) check("a_frame_start_one_clk", a_fs, 0);
      if (a_hs == 1'b0) begin
        n_low++;
        if (first_low < 0) first_low = a_hc;
        last_low = a_hc;
      end
      if (!a_vo && vid_prev && fall_h < 0) fall_h = a_hc;
      vid_prev = a_vo;
      if (a_ls) begin
        found = 1;
        break;
      end
    end
    check("a_line_start_seen", found, 1);
    check("a_line_period", cyc, 800);
    check("a_hsync_low_cycles", n_low, 96);
    check("a_hsync_first_low_h", first_low, 656);
    check("a_hsync_last_low_h", last_low, 751);
    check("a_video_fall_h", fall_h, 640);
    check("a_line2_h", a_hc, 0);
    check("a_line2_v", a_vc, 1);
    check("a_line2_frame_start", a_fs, 0);

    // ---------------- A: asynchronous reset mid-line ----------------
    found = 0;
    for (int k = 0; k < 1000; k++) begin
      if (a_hc == 10'd700) begin
        found = 1;
        break;
      end
      step();
    end
    check("a_reach_h700", found, 1);
    check("a_hsync_low_at_700", a_hs, 0);
    #2;
    a_rst = 0;
    #1;
    check("a_async_hsync", a_hs, 1);
    check("a_async_h", a_hc, 799);
    check("a_async_v", a_vc, 524);
    check("a_async_video_on", a_vo, 0);
    step();
    step();
    a_rst = 1;
    step();
    check("a_rerelease_h", a_hc, 0);
    check("a_rerelease_v", a_vc, 0);
    check("a_rerelease_frame_start", a_fs, 1);
    a_rst = 0;

    // ---------------- B: small timing, two frames ----------------
    b_rst = 1;
    step();
    check("b_first_h", b_hc, 0);
    check("b_first_v", b_vc, 0);
    check("b_first_frame_start", b_fs, 1);
    vs_bad = 0; hs_bad = 0; seq_bad = 0; exp_line = 0;
    fs_cnt = 0; last_fs = 0; fs_period = 0; vs_low = 0;
    for (int c = 1; c <= 192; c++) begin
      step();
      if (b_vs != ((b_vc == 10'd5) ? 1'b0 : 1'b1)) vs_bad++;
      if (b_hs != ((b_hc == 10'd9 || b_hc == 10'd10) ? 1'b0 : 1'b1)) hs_bad++;
      if (b_vs == 1'b0) vs_low++;
      if (b_ls) begin
        exp_line = (exp_line + 1) % 8;
        if (b_vc != 10'(exp_line)) seq_bad++;
      end
      if (b_fs) begin
        fs_cnt++;
        fs_period = c - last_fs;
        last_fs = c;
      end
    end
    check("b_vsync_vs_line", vs_bad, 0);
    check("b_hsync_vs_col", hs_bad, 0);
    check("b_vsync_low_cycles", vs_low, 24);
    check("b_v_sequence", seq_bad, 0);
    check("b_frame_starts", fs_cnt, 2);
    check("b_frame_period", fs_period, 96);

    // ---------------- B: Enable dropped mid-frame ----------------
    found = 0;
    for (int k = 0; k < 200; k++) begin
      if (b_vc == 10'd3) begin
        found = 1;
        break;
      end
      step();
    end
    check("b_reach_v3", found, 1);
    b_en = 0;
    step();
    check("b_dis_h", b_hc, 11);
    check("b_dis_v", b_vc, 7);
    check("b_dis_video_on", b_vo, 0);
    check("b_dis_pix_tick", b_pt, 0);
    check("b_dis_hsync", b_hs, 1);
    check("b_dis_vsync", b_vs, 1);
    repeat (9) step();
    check("b_hold_h", b_hc, 11);
    check("b_hold_line_start", b_ls, 0);
    b_en = 1;
    step();
    check("b_reen_frame_start", b_fs, 1);
    check("b_reen_h", b_hc, 0);
    check("b_reen_v", b_vc, 0);
    b_rst = 0;

    // ---------------- C: divide-by-4 ----------------
    c_rst = 1;
    cyc = 0; found = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      cyc++;
      if (c_pt) begin
        found = 1;
        break;
      end
      if (c_hc != 10'd799) stable_bad++;
    end
    check("c_first_tick_seen", found, 1);
    check("c_first_tick_edge", cyc, 4);
    check("c_first_h", c_hc, 0);
    check("c_first_v", c_vc, 0);
    check("c_first_frame_start", c_fs, 1);
    cyc = 0; stable_bad = 0; tick_bad = 0; prev_h = 0; found = 0;
    for (int k = 0; k < 5000; k++) begin
      step();
      cyc++;
      if (c_pt != ((cyc % 4) == 0)) tick_bad++;
      if (!c_pt && c_hc != 10'(prev_h)) stable_bad++;
      if (c_ls && !c_pt) tick_bad++;
      prev_h = c_hc;
      if (c_ls) begin
        found = 1;
        break;
      end
    end
    check("c_line_start_seen", found, 1);
    check("c_line_period", cyc, 3200);
    check("c_tick_every_4", tick_bad, 0);
    check("c_counts_stable", stable_bad, 0);
    check("c_line2_v", c_vc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
